dcache_tag_access_ctrl: RTL and testbench

//  Owns the L1 dcache tag/valid state and schedules the three agents that need it:
//  - core probe (lookup)
//  - refill allocate (MSHR return)
//  - invalidate-all sweep (flush)
//  One access per cycle, fixed priority, registered probe result. Victim selection per set

---
 rtl/dcache_pkg.sv | 16 +
 rtl/tag_checker.sv | 22 ++
 rtl/tag_victim_sel.sv | 30 +++
 rtl/dcache_tag_access_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dcache_tag_access_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared L1 dcache tag-path parameters and FSM state type.
// Optional perf counters in the top are enabled by DCACHE_TAG_PERF_CNT_EN.
package dcache_pkg;

  localparam int DCACHE_NUM_SET  = 32;
  localparam int DCACHE_NUM_WAY  = 4;
  localparam int DCACHE_TAG_BITS = 20;
  localparam int DCACHE_SET_BITS = $clog2(DCACHE_NUM_SET);
  localparam int DCACHE_WAY_BITS = $clog2(DCACHE_NUM_WAY);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/tag_checker.sv
// Combinational tag compare across the ways of one set.
// Produces a one-hot hit mask gated by the valid bits.
module tag_checker #(
  parameter int NUM_WAY  = 4,
  parameter int TAG_BITS = 20
) (
  input  logic [NUM_WAY-1:0][TAG_BITS-1:0] tag_row,
  input  logic [NUM_WAY-1:0]               valid_row,
  input  logic [TAG_BITS-1:0]              tag,
  output logic                             hit,
  output logic [NUM_WAY-1:0]               waymask
);

  always_comb begin
    waymask = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      waymask[w] = valid_row[w] && (tag_row[w] == tag);
    end
    hit = |waymask;
  end

endmodule

// File: rtl/tag_victim_sel.sv
// Victim way selection: lowest invalid way first,
// otherwise the way named by the set's round-robin pointer.
module tag_victim_sel #(
  parameter int NUM_WAY  = 4,
  parameter int WAY_BITS = 2
) (
  input  logic [NUM_WAY-1:0]  valid_row,
  input  logic [WAY_BITS-1:0] rr_ptr,
  output logic [NUM_WAY-1:0]  victim,
  output logic                use_invalid
);

  always_comb begin
    victim      = '0;
    use_invalid = ~&valid_row;
    unique case (1'b1)
      use_invalid: begin
        // Descending scan so the lowest invalid way wins.
        for (int i = NUM_WAY - 1; i >= 0; i--) begin
          if (!valid_row[i]) begin
            victim    = '0;
            victim[i] = 1'b1;
          end
        end
      end
      default: victim[rr_ptr] = 1'b1;
    endcase
  end

endmodule

// File: rtl/dcache_tag_access_ctrl.sv
// L1 dcache tag/valid owner: probe, refill and flush-sweep arbitration.
// Define DCACHE_TAG_PERF_CNT_EN to build the hit/miss counters.
module dcache_tag_access_ctrl
  import dcache_pkg::*;
#(
  parameter int  NUM_SET  = DCACHE_NUM_SET,
  parameter int  NUM_WAY  = DCACHE_NUM_WAY,
  parameter int  TAG_BITS = DCACHE_TAG_BITS,
  localparam int SET_BITS = $clog2(NUM_SET),
  localparam int WAY_BITS = $clog2(NUM_WAY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                probe_valid_i,
  output logic                probe_ready_o,
  input  logic [SET_BITS-1:0] probe_set_i,
  input  logic [TAG_BITS-1:0] probe_tag_i,
  output logic                resp_valid_o,
  output logic                resp_hit_o,
  output logic [NUM_WAY-1:0]  resp_waymask_o,
  input  logic                refill_valid_i,
  output logic                refill_ready_o,
  input  logic [SET_BITS-1:0] refill_set_i,
  input  logic [TAG_BITS-1:0] refill_tag_i,
  output logic                refill_done_o,
  output logic [NUM_WAY-1:0]  refill_waymask_o,
  output logic                evict_valid_o,
  output logic [TAG_BITS-1:0] evict_tag_o,
  input  logic                flush_req_i,
  output logic                flush_busy_o,
  output logic                flush_done_o,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o
);

  state_e state_q, state_d;
  logic [SET_BITS-1:0] sweep_q;

  logic [NUM_WAY-1:0][TAG_BITS-1:0] tag_q [NUM_SET];
  logic [NUM_WAY-1:0]               valid_q [NUM_SET];
  logic [WAY_BITS-1:0]              rr_q [NUM_SET];

  logic flush_step;
  logic sweep_last;
  logic probe_fire;
  logic refill_fire;

  logic                chk_hit;
  logic [NUM_WAY-1:0]  chk_mask;
  logic [NUM_WAY-1:0]  victim;
  logic                use_invalid;
  logic [NUM_WAY-1:0]  ref_valid;
  logic [TAG_BITS-1:0] evict_tag;

  assign sweep_last  = sweep_q == SET_BITS'(NUM_SET - 1);
  assign probe_fire  = probe_valid_i & probe_ready_o;
  assign refill_fire = refill_valid_i & refill_ready_o;
  assign ref_valid   = valid_q[refill_set_i];

  always_comb begin
    state_d        = state_q;
    flush_step     = 1'b0;
    refill_ready_o = 1'b0;
    probe_ready_o  = 1'b0;
    flush_busy_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Readies held low while reset is asserted.
        refill_ready_o = !rst && !flush_req_i;
        probe_ready_o  = !rst && !flush_req_i && !refill_valid_i;
        if (flush_req_i) state_d = FLUSH;
      end
      FLUSH: begin
        flush_step   = 1'b1;
        flush_busy_o = 1'b1;
        if (sweep_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_step) sweep_q <= sweep_q + 1'b1;
    end
  end

  tag_checker #(
    .NUM_WAY (NUM_WAY),
    .TAG_BITS(TAG_BITS)
  ) u_tag_checker (
    .tag_row  (tag_q[probe_set_i]),
    .valid_row(valid_q[probe_set_i]),
    .tag      (probe_tag_i),
    .hit      (chk_hit),
    .waymask  (chk_mask)
  );

  tag_victim_sel #(
    .NUM_WAY (NUM_WAY),
    .WAY_BITS(WAY_BITS)
  ) u_tag_victim_sel (
    .valid_row  (ref_valid),
    .rr_ptr     (rr_q[refill_set_i]),
    .victim     (victim),
    .use_invalid(use_invalid)
  );

  always_comb begin
    evict_tag = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (victim[w]) evict_tag = tag_q[refill_set_i][w];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SET; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (flush_step) begin
      valid_q[sweep_q] <= '0;
      rr_q[sweep_q]    <= '0;
    end else if (refill_fire) begin
      valid_q[refill_set_i] <= ref_valid | victim;
      if (!use_invalid) rr_q[refill_set_i] <= rr_q[refill_set_i] + 1'b1;
    end
  end

  // Tag storage is unreset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (refill_fire) begin
      for (int w = 0; w < NUM_WAY; w++) begin
        if (victim[w]) tag_q[refill_set_i][w] <= refill_tag_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_o     <= 1'b0;
      resp_hit_o       <= 1'b0;
      resp_waymask_o   <= '0;
      refill_done_o    <= 1'b0;
      refill_waymask_o <= '0;
      evict_valid_o    <= 1'b0;
      evict_tag_o      <= '0;
      flush_done_o     <= 1'b0;
    end else begin
      resp_valid_o     <= probe_fire;
      resp_hit_o       <= probe_fire & chk_hit;
      resp_waymask_o   <= probe_fire ? chk_mask : '0;
      refill_done_o    <= refill_fire;
      refill_waymask_o <= refill_fire ? victim : '0;
      evict_valid_o    <= refill_fire & (|(victim & ref_valid));
      evict_tag_o      <= refill_fire ? evict_tag : '0;
      flush_done_o     <= flush_step & sweep_last;
    end
  end

`ifdef DCACHE_TAG_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (resp_valid_o) begin
      if (resp_hit_o) hit_cnt_o <= hit_cnt_o + 32'd1;
      else            miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_tag_access_ctrl.sv
// Directed bench for dcache_tag_access_ctrl (default 32 sets x 4 ways).
// Covers probe, refill/victim order, priority, flush sweep and reset abort.
module tb_dcache_tag_access_ctrl;

  localparam int SB = 5;
  localparam int NW = 4;
  localparam int TB = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          probe_valid = 1'b0;
  logic          probe_ready;
  logic [SB-1:0] probe_set = '0;
  logic [TB-1:0] probe_tag = '0;
  logic          resp_valid;
  logic          resp_hit;
  logic [NW-1:0] resp_waymask;
  logic          refill_valid = 1'b0;
  logic          refill_ready;
  logic [SB-1:0] refill_set = '0;
  logic [TB-1:0] refill_tag = '0;
  logic          refill_done;
  logic [NW-1:0] refill_waymask;
  logic          evict_valid;
  logic [TB-1:0] evict_tag;
  logic          flush_req = 1'b0;
  logic          flush_busy;
  logic          flush_done;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_tag_access_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .probe_valid_i   (probe_valid),
    .probe_ready_o   (probe_ready),
    .probe_set_i     (probe_set),
    .probe_tag_i     (probe_tag),
    .resp_valid_o    (resp_valid),
    .resp_hit_o      (resp_hit),
    .resp_waymask_o  (resp_waymask),
    .refill_valid_i  (refill_valid),
    .refill_ready_o  (refill_ready),
    .refill_set_i    (refill_set),
    .refill_tag_i    (refill_tag),
    .refill_done_o   (refill_done),
    .refill_waymask_o(refill_waymask),
    .evict_valid_o   (evict_valid),
    .evict_tag_o     (evict_tag),
    .flush_req_i     (flush_req),
    .flush_busy_o    (flush_busy),
    .flush_done_o    (flush_done),
    .hit_cnt_o       (hit_cnt),
    .miss_cnt_o      (miss_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe_cycle(input logic [SB-1:0] s, input logic [TB-1:0] t);
    probe_valid = 1'b1;
    probe_set   = s;
    probe_tag   = t;
    step();
    probe_valid = 1'b0;
  endtask

  task automatic refill_cycle(input logic [SB-1:0] s, input logic [TB-1:0] t);
    refill_valid = 1'b1;
    refill_set   = s;
    refill_tag   = t;
    step();
    refill_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({resp_valid, resp_hit, refill_done, evict_valid, flush_busy, flush_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000000",
        {resp_valid, resp_hit, refill_done, evict_valid, flush_busy, flush_done});
    end
    checks++;
    if ({probe_ready, refill_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got=%b want=00", {probe_ready, refill_ready});
    end
    checks++;
    if ({resp_waymask, refill_waymask, evict_tag} !== '0) begin
      errors++;
      $display("FAIL reset_vectors got=%h want=0", {resp_waymask, refill_waymask, evict_tag});
    end
    checks++;
    if ({hit_cnt, miss_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%h want=0", {hit_cnt, miss_cnt});
    end
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({probe_ready, refill_ready} !== 2'b11) begin
      errors++;
      $display("FAIL post_reset_ready got=%b want=11", {probe_ready, refill_ready});
    end
  endtask

  task automatic test_probe_miss();
    probe_cycle(5'd3, 20'h12345);
    checks++;
    if ({resp_valid, resp_hit, resp_waymask} !== 6'b10_0000) begin
      errors++;
      $display("FAIL probe_miss got=%b want=100000", {resp_valid, resp_hit, resp_waymask});
    end
  endtask

  task automatic test_refill_then_hit();
    refill_cycle(5'd3, 20'hABCDE);
    checks++;
    if ({refill_done, refill_waymask, evict_valid} !== 6'b1_0001_0) begin
      errors++;
      $display("FAIL refill_empty got=%b want=100010",
        {refill_done, refill_waymask, evict_valid});
    end
    probe_cycle(5'd3, 20'hABCDE);
    checks++;
    if ({resp_valid, resp_hit, resp_waymask} !== 6'b11_0001) begin
      errors++;
      $display("FAIL probe_hit got=%b want=110001", {resp_valid, resp_hit, resp_waymask});
    end
  endtask

  task automatic test_victim_rr();
    logic [NW-1:0] want_mask [6];
    logic          want_ev   [6];
    logic [TB-1:0] want_tag  [6];
    want_mask = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    want_ev   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    want_tag  = '{20'h0, 20'h0, 20'h0, 20'h0, 20'h1, 20'h2};
    for (int i = 0; i < 6; i++) begin
      refill_cycle(5'd7, TB'(i + 1));
      checks++;
      if (refill_done !== 1'b1 || refill_waymask !== want_mask[i] ||
          evict_valid !== want_ev[i] || (want_ev[i] && evict_tag !== want_tag[i])) begin
        errors++;
        $display("FAIL victim_rr[%0d] got=%b/%b/%b/%h want=1/%b/%b/%h", i,
          refill_done, refill_waymask, evict_valid, evict_tag,
          want_mask[i], want_ev[i], want_tag[i]);
      end
    end
  endtask

  task automatic test_priority();
    refill_valid = 1'b1;
    refill_set   = 5'd9;
    refill_tag   = 20'h00055;
    probe_valid  = 1'b1;
    probe_set    = 5'd9;
    probe_tag    = 20'h00055;
    #1;
    checks++;
    if ({refill_ready, probe_ready} !== 2'b10) begin
      errors++;
      $display("FAIL prio_ready got=%b want=10", {refill_ready, probe_ready});
    end
    step();
    refill_valid = 1'b0;
    #1;
    checks++;
    if ({refill_done, resp_valid, probe_ready} !== 3'b101) begin
      errors++;
      $display("FAIL prio_second got=%b want=101", {refill_done, resp_valid, probe_ready});
    end
    step();
    probe_valid = 1'b0;
    checks++;
    if ({resp_valid, resp_hit, resp_waymask} !== 6'b11_0001) begin
      errors++;
      $display("FAIL prio_probe got=%b want=110001", {resp_valid, resp_hit, resp_waymask});
    end
  endtask

  task automatic test_flush();
    int  busy_cycles;
    bit  done_seen;
    refill_valid = 1'b1;
    refill_set   = 5'd11;
    refill_tag   = 20'h00077;
    flush_req    = 1'b1;
    #1;
    checks++;
    if ({refill_ready, probe_ready} !== 2'b00) begin
      errors++;
      $display("FAIL flush_prio got=%b want=00", {refill_ready, probe_ready});
    end
    step();
    refill_valid = 1'b0;
    flush_req    = 1'b0;
    checks++;
    if (refill_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_refill got=%b want=0", refill_done);
    end
    busy_cycles = 0;
    done_seen   = 1'b0;
    for (int i = 0; i < 48 && !done_seen; i++) begin
      if (i == 5) flush_req = 1'b1;
      if (i == 6) flush_req = 1'b0;
      if (flush_done) done_seen = 1'b1;
      else begin
        if (flush_busy) busy_cycles++;
        step();
      end
    end
    checks++;
    if (!done_seen || busy_cycles != 32 || flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_sweep got done=%0d busy_cycles=%0d busy=%b want done=1 busy_cycles=32 busy=0",
        done_seen, busy_cycles, flush_busy);
    end
    step();
    checks++;
    if (flush_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_pulse got=%b want=0", flush_done);
    end
    probe_cycle(5'd3, 20'hABCDE);
    checks++;
    if ({resp_valid, resp_hit} !== 2'b10) begin
      errors++;
      $display("FAIL flush_miss3 got=%b want=10", {resp_valid, resp_hit});
    end
    probe_cycle(5'd7, 20'h00005);
    checks++;
    if ({resp_valid, resp_hit} !== 2'b10) begin
      errors++;
      $display("FAIL flush_miss7 got=%b want=10", {resp_valid, resp_hit});
    end
    refill_cycle(5'd7, 20'h00009);
    checks++;
    if ({refill_waymask, evict_valid} !== 5'b0001_0) begin
      errors++;
      $display("FAIL flush_realloc got=%b want=00010", {refill_waymask, evict_valid});
    end
  endtask

  task automatic test_perf_cnt();
`ifdef DCACHE_TAG_PERF_CNT_EN
    checks++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd3) begin
      errors++;
      $display("FAIL perf_cnt got hit=%0d miss=%0d want hit=2 miss=3", hit_cnt, miss_cnt);
    end
`else
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_cnt_tied got hit=%0d miss=%0d want 0/0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_flush();
    int done_cnt;
    int busy_cnt;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    #1;
    checks++;
    if ({flush_busy, flush_done, resp_valid, refill_done, probe_ready, refill_ready} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_flush got=%b want=000000",
        {flush_busy, flush_done, resp_valid, refill_done, probe_ready, refill_ready});
    end
    step();
    rst = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (flush_done) done_cnt++;
      if (flush_busy) busy_cnt++;
      step();
    end
    checks++;
    if (done_cnt != 0 || busy_cnt != 0) begin
      errors++;
      $display("FAIL rst_abort got done=%0d busy=%0d want 0/0", done_cnt, busy_cnt);
    end
    checks++;
    if ({probe_ready, refill_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rst_idle got=%b want=11", {probe_ready, refill_ready});
    end
    probe_cycle(5'd7, 20'h00009);
    checks++;
    if ({resp_valid, resp_hit} !== 2'b10) begin
      errors++;
      $display("FAIL rst_cleared got=%b want=10", {resp_valid, resp_hit});
    end
  endtask

  initial begin
    test_reset();
    test_probe_miss();
    test_refill_then_hit();
    test_victim_rr();
    test_priority();
    test_flush();
    test_perf_cnt();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
